// File: rtl/dmac_arb_pkg.sv
// dmac_arb_pkg: shared types and constants for the dmac_arbiter slice.
// Lock keys are only consumed when DMAC_ARB_LOCK_EN is defined.
package dmac_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam logic [6:0] ARB_KEY_A   = 7'b0110101;  // phases 0..3
  localparam logic [6:0] ARB_KEY_B   = 7'b1011100;  // phases 4..7
  localparam int         ARB_TIMEOUT = 15;          // default BUSY hold limit
  localparam int         ARB_NREQ    = 4;           // default requester count

endpackage

// File: rtl/dmac_arbiter_if.sv
// dmac_arbiter_if: requester/dmac handshake bundle around the arbiter.
// master = arbiter side, slave = requesters plus dmac side.
// keyinput exists only when DMAC_ARB_LOCK_EN is defined.
interface dmac_arbiter_if
  import dmac_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ
) ();
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            start;
  logic            timeout_err;
`ifdef DMAC_ARB_LOCK_EN
  logic [6:0]      keyinput;
`endif

  modport master (
`ifdef DMAC_ARB_LOCK_EN
    input  keyinput,
`endif
    input  req, done,
    output gnt, owner, start, timeout_err
  );

  modport slave (
`ifdef DMAC_ARB_LOCK_EN
    output keyinput,
`endif
    output req, done,
    input  gnt, owner, start, timeout_err
  );
endinterface

// File: rtl/dmac_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches last+1, last+2, ...
// modulo NREQ and returns the first requesting index, so the previous
// owner is always considered last.
module rr_pick
  import dmac_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ,
  parameter int W    = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    last,
  output logic            valid,
  output logic [W-1:0]    idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NREQ]) begin
        valid = 1'b1;
        idx   = W'((int'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/dmac_arbiter.sv
// dmac_arbiter: round-robin arbiter/sequencer in front of one dmac channel.
// IDLE -> START (one-cycle start pulse) -> BUSY (until done, withdraw or
// timeout) -> RELEASE -> IDLE. All outputs are registered.
// Optional phase-keyed lock: define DMAC_ARB_LOCK_EN.
module dmac_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int NREQ    = ARB_NREQ,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active low
  dmac_arbiter_if.master bus
);

  localparam int         W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] TMO = 4'(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    owner_q, owner_d;
  logic [W-1:0]    last_q, last_d;
  logic [3:0]      timer_q, timer_d;
  logic            start_q, start_d;
  logic            terr_q, terr_d;
  logic            pick_valid;
  logic [W-1:0]    pick_idx;
  logic [3:0]      timer_inc;
  logic            timeout_hit;
  logic            key_ok;

  rr_pick #(.NREQ(NREQ), .W(W)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Saturating BUSY cycle count as it will be after this edge.
  assign timer_inc = (timer_q == 4'hF) ? 4'hF : timer_q + 4'd1;

`ifdef DMAC_ARB_LOCK_EN
  logic [2:0] phase_q;

  // Free-running phase counter selecting which key is expected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= 3'd0;
    else      phase_q <= phase_q + 3'd1;
  end

  assign key_ok = (bus.keyinput == (phase_q[2] ? ARB_KEY_B : ARB_KEY_A));
`else
  assign key_ok = 1'b1;
`endif

  // State and registered outputs; reset drops the grant with no RELEASE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= W'(NREQ - 1);
      timer_q <= 4'd0;
      start_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      start_q <= start_d;
      terr_q  <= terr_d;
    end
  end

  // Next state: done beats withdraw beats timeout; a bad key forces RELEASE.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE:    if (pick_valid) state_d = ST_START;
      ST_START:   state_d = ST_BUSY;
      ST_BUSY: begin
        if (bus.done || !bus.req[owner_q]) begin
          state_d = ST_RELEASE;
        end else if (timer_inc == TMO) begin
          state_d     = ST_RELEASE;
          timeout_hit = 1'b1;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
    if (!key_ok) state_d = ST_RELEASE;
  end

  // Output/datapath next values, keyed off the state being entered.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    gnt_d   = '0;
    start_d = 1'b0;
    terr_d  = timeout_hit;
    case (state_q)
      ST_IDLE:    if (pick_valid) owner_d = pick_idx;
      ST_START:   timer_d = 4'd0;
      ST_BUSY:    timer_d = timer_inc;
      default:    last_d  = owner_q;
    endcase
    if (state_d == ST_START || state_d == ST_BUSY) gnt_d[owner_d] = 1'b1;
    if (state_d == ST_START) start_d = 1'b1;
  end

  assign bus.gnt         = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.start       = start_q;
  assign bus.timeout_err = terr_q;

endmodule
